// File: rtl/gat_feat_reader_if.sv
// Feature-reader bus bundle: readout control, BRAM read port and output stream.
// master: the reader (drives addrb, stream, busy/done); slave: the environment.
// Ports: start/num_words/gat_ready control, feat_bram_addrb/dout, m_t* stream, busy/done status.
interface gat_feat_reader_if #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_ADDR_W = 16
);
  logic                            start;
  logic [NEW_FEATURE_ADDR_W:0]     num_words;
  logic                            gat_ready;
  logic                            busy;
  logic                            done;
  logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb;
  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout;
  logic [NEW_FEATURE_WIDTH-1:0]    m_tdata;
  logic                            m_tvalid;
  logic                            m_tlast;
  logic                            m_tready;

  modport master (
    input  start, num_words, gat_ready, feat_bram_dout, m_tready,
    output busy, done, feat_bram_addrb, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output start, num_words, gat_ready, feat_bram_dout, m_tready,
    input  busy, done, feat_bram_addrb, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/gat_feat_reader.sv
// Purpose: streams num_words feature words from a BRAM (addresses 0..N-1) to a valid/ready output.
// Latency: first beat BRAM_RD_LATENCY+3 cycles after start (with gat_ready high); 1 word/cycle sustained.
// Backpressure: reads are issued only while in-flight + buffered words fit the FIFO; m_tready stalls hold data.
// Ports: clk, rst (sync, active-high), bus (gat_feat_reader_if.master), optional rd_checksum.
// Optional feature: define GAT_FEAT_RD_CHECKSUM_EN to add rd_checksum (32-bit sum of output words).
module gat_feat_reader #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_ADDR_W = 16,
  parameter int BRAM_RD_LATENCY    = 2,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                clk,
  input  logic                rst,
  gat_feat_reader_if.master   bus
`ifdef GAT_FEAT_RD_CHECKSUM_EN
  ,
  output logic [31:0]         rd_checksum
`endif
);
  localparam int W    = NEW_FEATURE_WIDTH;
  localparam int AW   = NEW_FEATURE_ADDR_W;
  localparam int NW   = AW + 1;
  localparam int LAT  = BRAM_RD_LATENCY;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + LAT + 3);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [NW-1:0]     idx_q, idx_d;
  logic [NW-1:0]     num_q, num_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  // Bit k is set during the k-th cycle after the address was presented; bit LAT marks valid dout.
  logic [LAT:0]      pipe_vld_q, pipe_vld_d;
  logic [LAT:0]      pipe_last_q, pipe_last_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      mem_q [FIFO_DEPTH];
  logic              last_mem_q [FIFO_DEPTH];

  logic              out_vld;
  logic              push;
  logic              pop;
  logic              issue;
  logic              issue_last;
  logic              credit_ok;
  logic [CW-1:0]     inflight;

  assign out_vld = (cnt_q != '0);
  assign push    = pipe_vld_q[LAT];
  assign pop     = out_vld & bus.m_tready;

  assign bus.m_tvalid        = out_vld;
  assign bus.m_tdata         = out_vld ? mem_q[rd_ptr_q] : '0;
  assign bus.m_tlast         = out_vld & last_mem_q[rd_ptr_q];
  assign bus.feat_bram_addrb = addr_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

  // Every issued read owns a FIFO slot from issue until it is popped. A word leaving the FIFO
  // this cycle frees its slot immediately, so a full pipeline keeps 1 word/cycle when drained.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LAT; i++) begin
      inflight = inflight + CW'(pipe_vld_q[i]);
    end
    credit_ok  = (inflight + CW'(cnt_q)) < (CW'(FIFO_DEPTH) + CW'(pop));
    issue      = (state_q == READ) && bus.gat_ready && credit_ok;
    issue_last = issue && (idx_q == (num_q - NW'(1)));
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    addr_d      = addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pipe_vld_d  = {pipe_vld_q[LAT-1:0], issue};
    pipe_last_d = {pipe_last_q[LAT-1:0], issue_last};
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + CNTW'(push) - CNTW'(pop);

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          num_d   = bus.num_words;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (bus.gat_ready) begin
          if (num_q == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d = {idx_q[AW-1:0], 2'b00};
          idx_d  = idx_q + NW'(1);
          if (issue_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Only beats of this readout are in the FIFO, so the tagged last beat ends it.
        if (pop && last_mem_q[rd_ptr_q]) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      num_q       <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Storage needs no reset: the occupancy count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]      <= bus.feat_bram_dout;
      last_mem_q[wr_ptr_q] <= pipe_last_q[LAT];
    end
  end

`ifdef GAT_FEAT_RD_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && bus.start) begin
      csum_d = '0;
    end else if (pop) begin
      csum_d = csum_q + 32'(bus.m_tdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign rd_checksum = csum_q;
`endif
endmodule

// File: tb/tb_gat_feat_reader.sv
module tb_gat_feat_reader;
  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int LAT   = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gat_feat_reader_if #(.NEW_FEATURE_WIDTH(W), .NEW_FEATURE_ADDR_W(AW)) bus ();

`ifdef GAT_FEAT_RD_CHECKSUM_EN
  logic [31:0] rd_checksum;
`endif

  gat_feat_reader #(
    .NEW_FEATURE_WIDTH (W),
    .NEW_FEATURE_ADDR_W(AW),
    .BRAM_RD_LATENCY   (LAT),
    .FIFO_DEPTH        (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef GAT_FEAT_RD_CHECKSUM_EN
    ,
    .rd_checksum(rd_checksum)
`endif
  );

  // BRAM model with two-cycle read latency: word i holds i+100.
  logic [W-1:0] bram_s1;
  always @(posedge clk) begin
    bram_s1            <= W'(bus.feat_bram_addrb >> 2) + W'(100);
    bus.feat_bram_dout <= bram_s1;
  end

  int           checks = 0;
  int           errors = 0;
  logic [W:0]   exp_q[$];
  logic [W:0]   obs_q[$];
  logic [AW+1:0] addr_log[$];
  logic [AW+1:0] addr_prev = '0;
  int           done_cnt = 0;
  int           stall_viol = 0;
  logic         stall_pend = 1'b0;
  logic [W:0]   stall_dat = '0;
  logic         busy_seen = 1'b0;
  logic [W:0]   e, o;
  int           d0;

  // Records what the DUT shows this cycle, then advances one clock (returns at negedge).
  task automatic tick();
    if (!rst && bus.m_tvalid && bus.m_tready) obs_q.push_back({bus.m_tlast, bus.m_tdata});
    if (bus.done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_seen = 1'b1;
    if (stall_pend && (bus.m_tvalid !== 1'b1 || {bus.m_tlast, bus.m_tdata} !== stall_dat)) stall_viol++;
    stall_pend = !rst && bus.m_tvalid && !bus.m_tready;
    stall_dat  = {bus.m_tlast, bus.m_tdata};
    if (bus.feat_bram_addrb !== addr_prev) begin
      addr_log.push_back(bus.feat_bram_addrb);
      addr_prev = bus.feat_bram_addrb;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), W'(100 + i)});
  endtask

  task automatic do_start(input int n);
    bus.num_words = (AW + 1)'(n);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.done, bus.m_tvalid, bus.m_tlast} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: busy/done/tvalid/tlast=%b required 0000", {bus.busy, bus.done, bus.m_tvalid, bus.m_tlast});
    end
    checks++;
    if (bus.feat_bram_addrb !== '0 || bus.m_tdata !== '0) begin
      errors++; $display("FAIL reset_buses: addrb=%h tdata=%h required 0", bus.feat_bram_addrb, bus.m_tdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.gat_ready = 1'b1;
    bus.m_tready  = 1'b1;
    addr_log.delete();
    d0 = done_cnt;
    push_exp(5);
    do_start(5);
    for (int k = 0; k < 200 && done_cnt == d0; k++) tick();
    repeat (4) tick();
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL basic_done: %0d pulses required 1", done_cnt - d0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL basic_beat: missing, required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL basic_beat: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra: %0d extra beats required 0", obs_q.size()); obs_q.delete(); end
    // Address 0 equals the post-reset value, so only the changes 4,8,12,16 are visible.
    checks++;
    if (addr_log.size() != 4) begin errors++; $display("FAIL basic_addr_count: %0d changes required 4", addr_log.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (addr_log[i] !== (AW + 2)'(4 * (i + 1))) begin
          errors++; $display("FAIL basic_addr: got %0d required %0d", addr_log[i], 4 * (i + 1));
        end
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b required 0", bus.busy); end
`ifdef GAT_FEAT_RD_CHECKSUM_EN
    checks++;
    if (rd_checksum !== 32'd510) begin errors++; $display("FAIL checksum: got %0d required 510", rd_checksum); end
`endif
  endtask

  task automatic test_zero();
    busy_seen = 1'b0;
    d0 = done_cnt;
    do_start(0);
    for (int k = 0; k < 50 && done_cnt == d0; k++) tick();
    repeat (4) tick();
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL zero_done: %0d pulses required 1", done_cnt - d0); end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL zero_beats: %0d beats required 0", obs_q.size()); obs_q.delete(); end
    checks++;
    if (busy_seen !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL zero_busy: seen=%b now=%b required 1 then 0", busy_seen, bus.busy);
    end
  endtask

  task automatic test_stall();
    stall_viol = 0;
    d0 = done_cnt;
    push_exp(20);
    do_start(20);
    for (int k = 0; k < 600 && done_cnt == d0; k++) begin
      bus.m_tready = (k >= 30 && k < 40) ? 1'b0 : ((k % 2) == 0);
      tick();
    end
    bus.m_tready = 1'b1;
    repeat (4) tick();
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL stall_done: %0d pulses required 1", done_cnt - d0); end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL stall_hold: %0d unstable stalls required 0", stall_viol); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL stall_beat: missing, required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL stall_beat: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL stall_extra: %0d extra beats required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_gat_wait();
    bus.gat_ready = 1'b0;
    bus.m_tready  = 1'b1;
    d0 = done_cnt;
    push_exp(8);
    do_start(8);
    addr_log.delete();
    repeat (15) tick();
    checks++;
    if (addr_log.size() != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL wait_idle: addr changes=%0d beats=%0d required 0 0", addr_log.size(), obs_q.size());
    end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b required 1", bus.busy); end
    // gat_ready also drops mid-read to pause issue while in-flight words finish.
    for (int k = 0; k < 300 && done_cnt == d0; k++) begin
      bus.gat_ready = !(k >= 3 && k < 9);
      tick();
    end
    bus.gat_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL wait_done: %0d pulses required 1", done_cnt - d0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL wait_beat: missing, required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL wait_beat: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL wait_extra: %0d extra beats required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_abort();
    bus.m_tready = 1'b1;
    d0 = done_cnt;
    do_start(10);
    for (int k = 0; k < 200 && obs_q.size() < 3; k++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.m_tvalid, bus.m_tlast} !== 4'b0 || bus.feat_bram_addrb !== '0 || bus.m_tdata !== '0) begin
      errors++; $display("FAIL abort_outputs: flags=%b addrb=%h tdata=%h required 0", {bus.busy, bus.done, bus.m_tvalid, bus.m_tlast}, bus.feat_bram_addrb, bus.m_tdata);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, W'(100 + i)});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL abort_beat: missing, required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL abort_beat: got %h required %h", o, e); end end
    end
    repeat (10) tick();
    checks++;
    if (done_cnt != d0 || obs_q.size() != 0) begin
      errors++; $display("FAIL abort_quiet: done=%0d beats=%0d required 0 0", done_cnt - d0, obs_q.size()); obs_q.delete();
    end
    push_exp(4);
    do_start(4);
    for (int k = 0; k < 200 && done_cnt == d0; k++) tick();
    repeat (3) tick();
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL abort_done: %0d pulses required 1", done_cnt - d0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL abort_fresh: missing, required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL abort_fresh: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL abort_extra: %0d extra beats required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_full_range();
    stall_viol = 0;
    d0 = done_cnt;
    push_exp(1 << AW);
    do_start(1 << AW);
    for (int k = 0; k < 1000 && done_cnt == d0; k++) begin
      bus.m_tready  = ($urandom_range(0, 3) != 0);
      // A start while busy must be ignored.
      bus.start     = (k == 10);
      bus.num_words = (k == 10) ? (AW + 1)'(3) : (AW + 1)'(1 << AW);
      tick();
    end
    bus.start    = 1'b0;
    bus.m_tready = 1'b1;
    repeat (4) tick();
    checks++;
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL full_done: %0d pulses required 1", done_cnt - d0); end
    checks++;
    if (bus.feat_bram_addrb !== (AW + 2)'(((1 << AW) - 1) * 4)) begin
      errors++; $display("FAIL full_addr: got %0d required %0d", bus.feat_bram_addrb, ((1 << AW) - 1) * 4);
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL full_hold: %0d unstable stalls required 0", stall_viol); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL full_beat: missing, required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL full_beat: got %h required %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL full_extra: %0d extra beats required 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.num_words = '0;
    bus.gat_ready = 1'b0;
    bus.m_tready  = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_gat_wait();
    test_reset_abort();
    test_full_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
